// File: rtl/data_to_axi_packer.sv
// Packs one DATA_WIDTH element per handshake into a wide AXI4-Stream beat, flushing on full or last.
// Optional idle flush of partial beats: define DATA_TO_AXI_PACKER_FLUSH_EN.
module data_to_axi_packer #(
  parameter int DATA_WIDTH   = 32,
  parameter int AXI_WIDTH    = 512,
  parameter int NUM_ELEMENTS = AXI_WIDTH / DATA_WIDTH,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_keep,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [AXI_WIDTH-1:0]    out_tdata,
  output logic [AXI_WIDTH/8-1:0]  out_tkeep,
  output logic                    out_tlast,
  output logic                    out_tvalid,
  input  logic                    out_tready
);
  localparam int CW  = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
  localparam int KW  = AXI_WIDTH / 8;
  localparam int BPE = DATA_WIDTH / 8;

  if (NUM_ELEMENTS < 2) begin : g_chk_ne
    $error("data_to_axi_packer: NUM_ELEMENTS must be >= 2");
  end
  if ((DATA_WIDTH % 8) != 0 || NUM_ELEMENTS * DATA_WIDTH != AXI_WIDTH) begin : g_chk_w
    $error("data_to_axi_packer: width parameters inconsistent");
  end
  if (FLUSH_CYCLES < 1) begin : g_chk_fc
    $error("data_to_axi_packer: FLUSH_CYCLES must be >= 1");
  end

  logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] acc_data_q, acc_data_d, merge_data;
  logic [NUM_ELEMENTS-1:0]                 acc_keep_q, acc_keep_d, merge_keep;
  logic [CW-1:0]                           cnt_q, cnt_d;
  logic [AXI_WIDTH-1:0]                    out_tdata_q, out_tdata_d;
  logic [KW-1:0]                           out_tkeep_q, out_tkeep_d;
  logic                                    out_tlast_q, out_tlast_d;
  logic                                    out_tvalid_q, out_tvalid_d;

  logic out_free, at_end, accept, complete, flush;

  function automatic logic [KW-1:0] widen(input logic [NUM_ELEMENTS-1:0] k);
    logic [KW-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_ELEMENTS; i++) r[i*BPE +: BPE] = {BPE{k[i]}};
    return r;
  endfunction

  assign out_free = !out_tvalid_q || out_tready;
  assign at_end   = (cnt_q == CW'(NUM_ELEMENTS - 1));
  // Only an element that closes a beat needs the output stage to be free.
  assign in_ready = out_free || (!at_end && !in_last);
  assign accept   = in_valid && in_ready;
  assign complete = accept && (at_end || in_last);

  always_comb begin
    merge_data        = acc_data_q;
    merge_keep        = acc_keep_q;
    merge_data[cnt_q] = in_data;
    merge_keep[cnt_q] = in_keep;
  end

`ifdef DATA_TO_AXI_PACKER_FLUSH_EN
  localparam int IW = $clog2(FLUSH_CYCLES + 1);
  logic [IW-1:0] idle_q;

  // idle_q counts earlier idle cycles, so the flush lands on the FLUSH_CYCLES-th idle cycle.
  assign flush = (cnt_q != '0) && !accept && out_free && (idle_q >= IW'(FLUSH_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else if (accept || flush) begin
      idle_q <= '0;
    end else if (cnt_q != '0 && idle_q < IW'(FLUSH_CYCLES - 1)) begin
      idle_q <= idle_q + IW'(1);
    end
  end
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    acc_data_d   = acc_data_q;
    acc_keep_d   = acc_keep_q;
    cnt_d        = cnt_q;
    out_tdata_d  = out_tdata_q;
    out_tkeep_d  = out_tkeep_q;
    out_tlast_d  = out_tlast_q;
    out_tvalid_d = out_tvalid_q;
    if (out_tvalid_q && out_tready) out_tvalid_d = 1'b0;
    if (complete) begin
      out_tdata_d  = merge_data;
      out_tkeep_d  = widen(merge_keep);
      out_tlast_d  = in_last;
      out_tvalid_d = 1'b1;
      cnt_d        = '0;
      acc_data_d   = '0;
      acc_keep_d   = '0;
    end else if (accept) begin
      acc_data_d = merge_data;
      acc_keep_d = merge_keep;
      cnt_d      = cnt_q + CW'(1);
    end else if (flush) begin
      out_tdata_d  = acc_data_q;
      out_tkeep_d  = widen(acc_keep_q);
      out_tlast_d  = 1'b0;
      out_tvalid_d = 1'b1;
      cnt_d        = '0;
      acc_data_d   = '0;
      acc_keep_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_data_q   <= '0;
      acc_keep_q   <= '0;
      cnt_q        <= '0;
      out_tdata_q  <= '0;
      out_tkeep_q  <= '0;
      out_tlast_q  <= 1'b0;
      out_tvalid_q <= 1'b0;
    end else begin
      acc_data_q   <= acc_data_d;
      acc_keep_q   <= acc_keep_d;
      cnt_q        <= cnt_d;
      out_tdata_q  <= out_tdata_d;
      out_tkeep_q  <= out_tkeep_d;
      out_tlast_q  <= out_tlast_d;
      out_tvalid_q <= out_tvalid_d;
    end
  end

  assign out_tdata  = out_tdata_q;
  assign out_tkeep  = out_tkeep_q;
  assign out_tlast  = out_tlast_q;
  assign out_tvalid = out_tvalid_q;
endmodule
